// File: rtl/dual_port_memory_responder_if.sv
// Bus bundle between the CPU's two memory interfaces and the memory responder.
//   readM1/address1 : instruction-fetch request (master -> responder)
//   data1/ack1      : fetch read data and completion pulse (responder -> master)
//   readM2/writeM2/address2 : data-port request (master -> responder)
//   ack2            : data-port completion pulse (responder -> master)
// The bidirectional data2 bus is a plain inout port on the responder so that it
// resolves as an ordinary tristate net at each end.
interface dual_port_memory_responder_if #(
  parameter int WORD_SIZE = 16
);
  logic                 readM1;
  logic [WORD_SIZE-1:0] address1;
  logic [WORD_SIZE-1:0] data1;
  logic                 ack1;
  logic                 readM2;
  logic                 writeM2;
  logic [WORD_SIZE-1:0] address2;
  logic                 ack2;

  modport master (
    output readM1, address1, readM2, writeM2, address2,
    input  data1, ack1, ack2
  );

  modport slave (
    input  readM1, address1, readM2, writeM2, address2,
    output data1, ack1, ack2
  );
endinterface

// File: rtl/dual_port_memory_responder.sv
// Memory-side responder for the CPU's fetch port (port 1, read-only) and data
// port (port 2, read/write). Each port runs its own IDLE/BUSY/ACK FSM that
// models a fixed access latency and signals completion with a one-cycle ack.
//   Clk    : rising-edge clock
//   Reset  : synchronous, active-high; clears FSMs and outputs, not storage
//   bus    : slave side of the request/ack bundle (see the interface file)
//   data2  : write data from the master, or read data driven only during the
//            ACK cycle of a port-2 read
module dual_port_memory_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  dual_port_memory_responder_if.slave bus,
  inout  wire  [WORD_SIZE-1:0]       data2
);
  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  state_t               st1, st1_nxt, st2, st2_nxt;
  logic [3:0]           cnt1, cnt2;
  logic [ADDR_BITS-1:0] addr1_q, addr2_q, idx1, idx2;
  logic [WORD_SIZE-1:0] data1_q, rdata2_q, wdata2_q, wdata2;
  logic                 wr2_q, is_wr2, req2, enter1, enter2, drive2;
  logic                 unused_addr_hi;

  // Upper address bits alias onto the storage index.
  assign unused_addr_hi = ^{bus.address1[WORD_SIZE-1:ADDR_BITS],
                            bus.address2[WORD_SIZE-1:ADDR_BITS]};

  // State registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st1 <= IDLE;
      st2 <= IDLE;
    end else begin
      st1 <= st1_nxt;
      st2 <= st2_nxt;
    end
  end

  // Next-state logic. The counter holds the edges left until ACK, so BUSY
  // moves on when the count would reach zero on this edge.
  always_comb begin
    req2    = bus.readM2 | bus.writeM2;
    st1_nxt = st1;
    st2_nxt = st2;
    unique case (st1)
      IDLE:    if (bus.readM1) st1_nxt = (LATENCY == 1) ? ACK : BUSY;
      BUSY:    if (!bus.readM1) st1_nxt = IDLE;
               else if (cnt1 == 4'd1) st1_nxt = ACK;
      ACK:     st1_nxt = IDLE;
      default: st1_nxt = IDLE;
    endcase
    unique case (st2)
      IDLE:    if (req2) st2_nxt = (LATENCY == 1) ? ACK : BUSY;
      BUSY:    if (!req2) st2_nxt = IDLE;
               else if (cnt2 == 4'd1) st2_nxt = ACK;
      ACK:     st2_nxt = IDLE;
      default: st2_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 acceptance and ACK entry share an edge, so the live
  // request fields are used when still in IDLE instead of the latched ones.
  always_comb begin
    enter1 = (st1_nxt == ACK);
    enter2 = (st2_nxt == ACK);
    idx1   = (st1 == IDLE) ? bus.address1[ADDR_BITS-1:0] : addr1_q;
    idx2   = (st2 == IDLE) ? bus.address2[ADDR_BITS-1:0] : addr2_q;
    is_wr2 = (st2 == IDLE) ? bus.writeM2 : wr2_q;
    wdata2 = (st2 == IDLE) ? data2 : wdata2_q;
  end

  // Request latching, latency counters and read-data registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt1     <= '0;
      cnt2     <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      wr2_q    <= 1'b0;
      wdata2_q <= '0;
      data1_q  <= '0;
      rdata2_q <= '0;
    end else begin
      if (st1 == IDLE && bus.readM1) begin
        cnt1    <= CNT_LOAD;
        addr1_q <= bus.address1[ADDR_BITS-1:0];
      end else if (st1 == BUSY) begin
        cnt1 <= cnt1 - 4'd1;
      end
      if (st2 == IDLE && req2) begin
        cnt2     <= CNT_LOAD;
        addr2_q  <= bus.address2[ADDR_BITS-1:0];
        wr2_q    <= bus.writeM2;
        wdata2_q <= data2;
      end else if (st2 == BUSY) begin
        cnt2 <= cnt2 - 4'd1;
      end
      // Reads sample storage before a same-edge write lands (read-before-write).
      if (enter1) data1_q <= mem[idx1];
      if (enter2 && !is_wr2) rdata2_q <= mem[idx2];
    end
  end

  // Storage is not cleared by reset; a reset edge discards a pending write.
  always_ff @(posedge Clk) begin
    if (!Reset && enter2 && is_wr2) mem[idx2] <= wdata2;
  end

  // Outputs
  always_comb begin
    bus.ack1  = (st1 == ACK);
    bus.data1 = data1_q;
    bus.ack2  = (st2 == ACK);
    drive2    = (st2 == ACK) && !wr2_q;
  end

  assign data2 = drive2 ? rdata2_q : 'z;
endmodule

// File: tb/tb_dual_port_memory_responder.sv
module tb_dual_port_memory_responder;
  localparam int WS  = 16;
  localparam int AB  = 8;
  localparam int LAT = 2;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  // Main DUT, LATENCY=2. data2 idles high when nobody drives it.
  dual_port_memory_responder_if #(.WORD_SIZE(WS)) bus ();
  tri1 [WS-1:0] data2;
  logic         d2_oe;
  logic [WS-1:0] d2_out;
  assign data2 = d2_oe ? d2_out : 'z;

  dual_port_memory_responder #(.WORD_SIZE(WS), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .data2(data2)
  );

  // Second DUT, LATENCY=1.
  dual_port_memory_responder_if #(.WORD_SIZE(WS)) bus_l1 ();
  tri1 [WS-1:0] data2_l1;
  logic         d2l_oe;
  logic [WS-1:0] d2l_out;
  assign data2_l1 = d2l_oe ? d2l_out : 'z;

  dual_port_memory_responder #(.WORD_SIZE(WS), .ADDR_BITS(AB), .LATENCY(1)) dut_l1 (
    .Clk(Clk), .Reset(Reset), .bus(bus_l1), .data2(data2_l1)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  task automatic chk(input string nm, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model of the main DUT: a transaction accepted at edge s
  // completes at edge s+LAT-1 (memory effect, ack in the following cycle) and
  // the port is free again from edge s+LAT. A request seen low before the
  // completion edge cancels it.
  logic          m_act1 = 1'b0, m_act2 = 1'b0, m_wr2 = 1'b0;
  int unsigned   m_st1 = 0, m_st2 = 0;
  logic [AB-1:0] m_a1, m_a2;
  logic [WS-1:0] m_wd2;
  logic [WS-1:0] e_d1 = '0, e_d2 = '0;
  logic          e_ack1 = 1'b0, e_ack2 = 1'b0, e_drv2 = 1'b0;
  logic [WS-1:0] mmem [1 << AB];

  always @(posedge Clk) begin
    logic f1, f2, r2;
    f1 = 1'b0;
    f2 = 1'b0;
    r2 = bus.readM2 | bus.writeM2;
    if (Reset) begin
      m_act1 = 1'b0;
      m_act2 = 1'b0;
      e_d1   = '0;
    end else begin
      if (!m_act1) begin
        if (bus.readM1) begin
          m_act1 = 1'b1; m_st1 = cyc; m_a1 = bus.address1[AB-1:0];
        end
      end else if (cyc == m_st1 + LAT || !bus.readM1) begin
        m_act1 = 1'b0;
      end
      f1 = m_act1 && (cyc == m_st1 + LAT - 1);

      if (!m_act2) begin
        if (r2) begin
          m_act2 = 1'b1; m_st2 = cyc; m_a2 = bus.address2[AB-1:0];
          m_wr2 = bus.writeM2; m_wd2 = data2;
        end
      end else if (cyc == m_st2 + LAT || !r2) begin
        m_act2 = 1'b0;
      end
      f2 = m_act2 && (cyc == m_st2 + LAT - 1);

      if (f1) e_d1 = mmem[m_a1];
      if (f2 && !m_wr2) e_d2 = mmem[m_a2];
      if (f2 && m_wr2) mmem[m_a2] = m_wd2;
    end
    e_ack1 = f1;
    e_ack2 = f2;
    e_drv2 = f2 && !m_wr2;
    cyc++;
  end

  // Cycle-by-cycle comparison of the main DUT against the model.
  always @(posedge Clk) begin
    #1;
    chk("m_ack1", {15'b0, bus.ack1}, {15'b0, e_ack1});
    chk("m_ack2", {15'b0, bus.ack2}, {15'b0, e_ack2});
    chk("m_data1", bus.data1, e_d1);
    chk("m_data2", data2, e_drv2 ? e_d2 : (d2_oe ? d2_out : 16'hFFFF));
  end

  task automatic wait_ack(input int port, output logic [WS-1:0] val);
    logic seen;
    seen = 1'b0;
    val  = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (port == 1 && bus.ack1) begin seen = 1'b1; val = bus.data1; break; end
      if (port == 2 && bus.ack2) begin seen = 1'b1; val = data2; break; end
    end
    chk("ack_seen", {15'b0, seen}, 16'd1);
  endtask

  task automatic wr2(input logic [WS-1:0] a, input logic [WS-1:0] d);
    logic [WS-1:0] v;
    @(negedge Clk);
    bus.writeM2 = 1'b1; bus.address2 = a; d2_oe = 1'b1; d2_out = d;
    wait_ack(2, v);
    bus.writeM2 = 1'b0; d2_oe = 1'b0;
  endtask

  task automatic rd1(input logic [WS-1:0] a, output logic [WS-1:0] v);
    @(negedge Clk);
    bus.readM1 = 1'b1; bus.address1 = a;
    wait_ack(1, v);
    bus.readM1 = 1'b0;
  endtask

  task automatic rd2(input logic [WS-1:0] a, output logic [WS-1:0] v);
    @(negedge Clk);
    bus.readM2 = 1'b1; bus.address2 = a;
    wait_ack(2, v);
    bus.readM2 = 1'b0;
  endtask

  function automatic logic [WS-1:0] rand_addr();
    logic [7:0] hi;
    logic [3:0] lo;
    hi = 8'($urandom);
    lo = 4'($urandom);
    return {hi, 4'h0, lo};
  endfunction

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [WS-1:0] v;
    logic          h1, h2;
    Reset = 1'b1;
    bus.readM1 = 1'b0; bus.address1 = '0; bus.readM2 = 1'b0; bus.writeM2 = 1'b0; bus.address2 = '0;
    bus_l1.readM1 = 1'b0; bus_l1.address1 = '0; bus_l1.readM2 = 1'b0; bus_l1.writeM2 = 1'b0;
    bus_l1.address2 = '0;
    d2_oe = 1'b0; d2_out = '0; d2l_oe = 1'b0; d2l_out = '0;

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ack1", {15'b0, bus.ack1}, 16'd0);
    chk("rst_ack2", {15'b0, bus.ack2}, 16'd0);
    chk("rst_data1", bus.data1, 16'h0000);
    chk("rst_data2_z", data2, 16'hFFFF);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 16; i++) wr2(16'(i), 16'h0000);

    // Write 0xBEEF to 0x0005: ack one cycle after the BUSY cycle, for one cycle.
    @(negedge Clk);
    bus.writeM2 = 1'b1; bus.address2 = 16'h0005; d2_oe = 1'b1; d2_out = 16'hBEEF;
    @(negedge Clk); chk("w_ack2_busy", {15'b0, bus.ack2}, 16'd0);
    @(negedge Clk); chk("w_ack2_pulse", {15'b0, bus.ack2}, 16'd1);
    bus.writeM2 = 1'b0; d2_oe = 1'b0;
    @(negedge Clk); chk("w_ack2_end", {15'b0, bus.ack2}, 16'd0);

    // Fetch 0x0005; data1 holds after the request drops.
    @(negedge Clk); bus.readM1 = 1'b1; bus.address1 = 16'h0005;
    @(negedge Clk); chk("r1_ack_busy", {15'b0, bus.ack1}, 16'd0);
    @(negedge Clk); chk("r1_ack", {15'b0, bus.ack1}, 16'd1);
    chk("r1_data", bus.data1, 16'hBEEF);
    bus.readM1 = 1'b0;
    @(negedge Clk); chk("r1_ack_end", {15'b0, bus.ack1}, 16'd0);
    chk("r1_hold", bus.data1, 16'hBEEF);

    // Port-2 read of an aliased address; data2 driven only in the ack cycle.
    @(negedge Clk); bus.readM2 = 1'b1; bus.address2 = 16'h0105;
    @(negedge Clk); chk("r2_z_busy", data2, 16'hFFFF);
    @(negedge Clk); chk("r2_ack", {15'b0, bus.ack2}, 16'd1);
    chk("r2_data", data2, 16'hBEEF);
    bus.readM2 = 1'b0;
    @(negedge Clk); chk("r2_z_after", data2, 16'hFFFF);

    // Same-edge write and fetch of 0x0007: fetch sees the old word.
    @(negedge Clk);
    bus.writeM2 = 1'b1; bus.address2 = 16'h0007; d2_oe = 1'b1; d2_out = 16'h1234;
    bus.readM1 = 1'b1; bus.address1 = 16'h0007;
    @(negedge Clk);
    @(negedge Clk);
    chk("coll_ack1", {15'b0, bus.ack1}, 16'd1);
    chk("coll_ack2", {15'b0, bus.ack2}, 16'd1);
    chk("coll_old", bus.data1, 16'h0000);
    bus.writeM2 = 1'b0; d2_oe = 1'b0; bus.readM1 = 1'b0;
    rd1(16'h0007, v); chk("coll_new", v, 16'h1234);

    // Write dropped during BUSY: no ack, storage unchanged.
    @(negedge Clk);
    bus.writeM2 = 1'b1; bus.address2 = 16'h0009; d2_oe = 1'b1; d2_out = 16'hCAFE;
    @(negedge Clk); bus.writeM2 = 1'b0; d2_oe = 1'b0;
    repeat (3) begin @(negedge Clk); chk("abort_ack2", {15'b0, bus.ack2}, 16'd0); end
    rd2(16'h0009, v); chk("abort_keep", v, 16'h0000);

    // Reset during BUSY: write discarded, acks low, data1 cleared.
    @(negedge Clk);
    bus.writeM2 = 1'b1; bus.address2 = 16'h0009; d2_oe = 1'b1; d2_out = 16'hCAFE;
    bus.readM1 = 1'b1; bus.address1 = 16'h0009;
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    bus.writeM2 = 1'b0; d2_oe = 1'b0; bus.readM1 = 1'b0;
    chk("rstb_data1", bus.data1, 16'h0000);
    repeat (3) begin
      chk("rstb_ack1", {15'b0, bus.ack1}, 16'd0);
      chk("rstb_ack2", {15'b0, bus.ack2}, 16'd0);
      @(negedge Clk);
    end
    rd1(16'h0009, v); chk("rstb_keep", v, 16'h0000);

    // Randomized traffic; the model and compare process do the checking.
    h1 = 1'b0; h2 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge Clk);
      Reset = ($urandom_range(0, 299) == 0);
      if (h1) begin
        if (bus.ack1 || $urandom_range(0, 15) == 0) begin bus.readM1 = 1'b0; h1 = 1'b0; end
      end else if ($urandom_range(0, 1) == 1) begin
        bus.readM1 = 1'b1; h1 = 1'b1;
      end
      bus.address1 = rand_addr();
      if (h2) begin
        if (bus.ack2 || $urandom_range(0, 15) == 0) begin
          bus.readM2 = 1'b0; bus.writeM2 = 1'b0; h2 = 1'b0;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0:       begin bus.readM2 = 1'b1; bus.writeM2 = 1'b0; end
          1:       begin bus.readM2 = 1'b0; bus.writeM2 = 1'b1; end
          default: begin bus.readM2 = 1'b1; bus.writeM2 = 1'b1; end
        endcase
        h2 = 1'b1;
      end
      bus.address2 = rand_addr();
      d2_oe  = bus.writeM2;
      d2_out = 16'($urandom_range(0, 65534));
    end
    @(negedge Clk);
    Reset = 1'b0;
    bus.readM1 = 1'b0; bus.readM2 = 1'b0; bus.writeM2 = 1'b0; d2_oe = 1'b0;
    repeat (3) @(negedge Clk);

    // LATENCY=1: read+write together acts as a write; held fetch acks every other cycle.
    bus_l1.readM2 = 1'b1; bus_l1.writeM2 = 1'b1; bus_l1.address2 = 16'h0003;
    d2l_oe = 1'b1; d2l_out = 16'h5A5A;
    @(negedge Clk); chk("l1_w_ack2", {15'b0, bus_l1.ack2}, 16'd1);
    bus_l1.readM2 = 1'b0; bus_l1.writeM2 = 1'b0; d2l_oe = 1'b0;
    @(negedge Clk); chk("l1_w_ack2_end", {15'b0, bus_l1.ack2}, 16'd0);
    bus_l1.readM1 = 1'b1; bus_l1.address1 = 16'h0003;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("l1_ack1_seq", {15'b0, bus_l1.ack1}, (i % 2 == 0) ? 16'd1 : 16'd0);
      if (i == 0) chk("l1_data1", bus_l1.data1, 16'h5A5A);
    end
    bus_l1.readM1 = 1'b0;
    bus_l1.readM2 = 1'b1; bus_l1.address2 = 16'h0103;
    @(negedge Clk);
    chk("l1_r2_ack", {15'b0, bus_l1.ack2}, 16'd1);
    chk("l1_r2_data", data2_l1, 16'h5A5A);
    bus_l1.readM2 = 1'b0;
    @(negedge Clk); chk("l1_r2_z", data2_l1, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_port_memory_responder.md
Name: dual_port_memory_responder

Overview:
- Memory-side responder for the CPU's two memory interfaces.
- Port 1 is the instruction fetch port (readM1/address1/data1). It is read-only.
- Port 2 is the data port (readM2/writeM2/address2/data2). It is read/write and data2 is bidirectional.
- Each port runs an independent FSM that models a fixed access latency and reports completion with a one-cycle ack. This replaces the zero-latency behavioural memory, so the multi-cycle CPU can be exercised against realistic stalls.

Parameters:
- WORD_SIZE, 16, width of data and address buses.
- ADDR_BITS, 8, number of address LSBs used to index storage; depth = 2^ADDR_BITS words.
- LATENCY, 2, cycles from request acceptance to ack; legal range 1..15.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  one clock; reset is synchronous and active-high.
- readM1  input  1  port-1 read request; held by master until ack1.
- address1  input  WORD_SIZE  port-1 word address; only [ADDR_BITS-1:0] is used.
- data1  output  WORD_SIZE  port-1 read data.
- ack1  output  1  port-1 completion pulse.
- readM2  input  1  port-2 read request.
- writeM2  input  1  port-2 write request.
- address2  input  WORD_SIZE  port-2 word address; only [ADDR_BITS-1:0] is used.
- data2  inout  WORD_SIZE  write data from master, or read data from the responder.
- ack2  output  1  port-2 completion pulse.

Behaviour:
- Storage: array of 2^ADDR_BITS words. Reset does not clear storage; it resets only the FSMs and outputs.
- Reset values: ack1=0, ack2=0, data1=0, data2 driver released (Z). Both FSMs go to IDLE and both counters clear.
- Per-port FSM states: IDLE, BUSY, ACK.
  - IDLE: at a rising edge with a request high, latch the address (and the write flag/data for port 2). Load counter = LATENCY-1.
    - If LATENCY=1, go directly to ACK.
    - Otherwise go to BUSY.
  - BUSY: decrement the counter each edge. When the counter is 0, go to ACK.
  - ACK: ack high for exactly one cycle, then IDLE. A new request can be accepted only from IDLE, so the minimum transaction period is LATENCY+1 cycles.
- Timing: if a request is first sampled at edge k, ack is high in the cycle after edge k+LATENCY-1.
- Port 1 read: data1 is registered from storage[latched addr] on the edge that enters ACK. data1 holds that value until the next port-1 read completes.
- Port 2 read: on entering ACK, register the read word. Drive data2 with it only while in ACK of a read transaction; data2 is Z in every other state.
- Port 2 write: data2 is sampled at acceptance. The storage write commits on the edge that enters ACK. data2 is never driven by the responder during a write.
- readM2 and writeM2 both high at acceptance: treated as a write.
- Request dropped while in BUSY: abort to IDLE on the next edge, with no ack, no write, and no change to data1.
- Address and data changes during BUSY are ignored, because the values are latched at acceptance.
- Same-address collision: if a port-2 write commits on the same edge a port-1 read enters ACK, port 1 returns the old data (read-before-write). The same rule applies to a port-2 read against its own concurrent write.
- Reset asserted mid-transaction: both FSMs go to IDLE on that edge, pending writes are discarded, and acks are forced low.
- Address wrap: upper address bits are ignored, so address 0x0100 aliases 0x0000 when ADDR_BITS=8.

Test Plan:
- Reset=1 for 2 cycles, then 0 → ack1=ack2=0, data1=0, data2=Z. Inject writeM2 with addr 0x0005, data 0xBEEF, LATENCY=2 → ack2 high exactly 2 cycles after acceptance, for 1 cycle.
- Then readM1 with address1=0x0005 → ack1 pulses after 2 cycles, data1=0xBEEF and holds after readM1 drops.
- readM2 at 0x0105 → ack2 pulse, data2=0xBEEF only during the ack cycle, Z before and after.
- Simultaneous port-2 write 0x1234 to 0x0007 (old 0x0000) committing on the same edge as a port-1 read of 0x0007 → data1=0x0000; a subsequent readM1 returns 0x1234.
- writeM2 accepted, then dropped during BUSY → no ack2; a read of that address returns the prior contents. Repeat the transaction with Reset asserted during BUSY → same result, acks stay 0.
- LATENCY=1 build: request held continuously → acks at cycles 1, 3, 5 (one per LATENCY+1 cycles). readM2 and writeM2 both high → a write is performed.
